// File: rtl/sp_inst_sequencer.sv
// sp_inst_sequencer: instruction ROM, issue/retire bookkeeping and protocol monitor for the SP core.
// Optional run_cycles_o / first_lat_o counters are compiled in when SP_SEQ_CYCLE_CNT_EN is defined.
module sp_inst_sequencer #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ROM_DEPTH = 512,
  parameter int EXEC_NUM  = 325,
  parameter int MAX_LAT   = 10,
  parameter int IDLE_CYC  = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         rom_we_i,
  input  logic [$clog2(ROM_DEPTH)-1:0] rom_waddr_i,
  input  logic [DATA_W-1:0]            rom_wdata_i,
  input  logic [ADDR_W-1:0]            inst_addr_i,
  input  logic                         out_valid_i,
  output logic                         in_valid_o,
  output logic [DATA_W-1:0]            inst_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [2:0]                   err_code_o,
  output logic [15:0]                  issued_cnt_o,
  output logic [15:0]                  retired_cnt_o
`ifdef SP_SEQ_CYCLE_CNT_EN
  ,
  output logic [31:0]                  run_cycles_o,
  output logic [3:0]                   first_lat_o
`endif
);

  localparam int              RA_W      = $clog2(ROM_DEPTH);
  localparam int              IX_W      = ADDR_W - 2;
  localparam logic [15:0]     EXEC_N    = 16'(EXEC_NUM);
  localparam logic [15:0]     LAT_LAST  = 16'(MAX_LAT - 1);
  localparam logic [3:0]      IDLE_LAST = 4'(IDLE_CYC - 1);
  localparam logic [IX_W-1:0] ROM_LIM   = IX_W'(ROM_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  state_e            state_q;
  logic [3:0]        wait_q;
  logic              in_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [2:0]        err_code_q;
  logic [15:0]       issued_q;
  logic [15:0]       retired_q;
  logic [15:0]       lat_q;

  logic [15:0]       issued_d;
  logic [15:0]       retired_d;
  logic [15:0]       lat_d;

  logic [DATA_W-1:0] rom_q [ROM_DEPTH];

  logic [IX_W-1:0]   idx_s;
  logic              idx_ok_s;
  logic              waddr_ok_s;
  logic              idle_like_s;
  logic              mon_s;
  logic              e_addr_s;
  logic              e_lat_s;
  logic              e_drop_s;
  logic              e_extra_s;
  logic              err_any_s;
  logic [2:0]        err_sel_s;

  always_comb begin
    idx_s       = inst_addr_i[ADDR_W-1:2];
    idx_ok_s    = (idx_s < ROM_LIM);
    waddr_ok_s  = (int'(rom_waddr_i) < ROM_DEPTH);
    idle_like_s = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);
    mon_s       = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    issued_d  = (issued_q  == 16'hFFFF) ? issued_q  : issued_q  + 16'd1;
    retired_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;
    lat_d     = (lat_q     == 16'hFFFF) ? lat_q     : lat_q     + 16'd1;

    // The latency window is the cycle the counter would reach MAX_LAT with still no retirement.
    e_addr_s  = in_valid_q && ((inst_addr_i[1:0] != 2'b00) || !idx_ok_s);
    e_lat_s   = mon_s && (EXEC_N != 16'd0) && (retired_q == 16'd0) && !out_valid_i
                && (lat_q >= LAT_LAST);
    e_drop_s  = mon_s && (retired_q != 16'd0) && (retired_q < EXEC_N) && !out_valid_i;
    e_extra_s = mon_s && (retired_q >= EXEC_N) && out_valid_i;
    err_any_s = e_addr_s || e_lat_s || e_drop_s || e_extra_s;

    if (e_addr_s) begin
      err_sel_s = 3'd4;
    end else if (e_lat_s) begin
      err_sel_s = 3'd1;
    end else if (e_drop_s) begin
      err_sel_s = 3'd2;
    end else if (e_extra_s) begin
      err_sel_s = 3'd3;
    end else begin
      err_sel_s = 3'd0;
    end
  end

  // Instruction ROM; contents survive reset and are writable only outside a run.
  always_ff @(posedge clk_i) begin
    if (rom_we_i && idle_like_s && waddr_ok_s) begin
      rom_q[rom_waddr_i] <= rom_wdata_i;
    end
  end

  always_comb begin
    if (in_valid_q && idx_ok_s) begin
      inst_o = rom_q[idx_s[RA_W-1:0]];
    end else begin
      inst_o = {DATA_W{1'b0}};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wait_q     <= 4'd0;
      in_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 3'd0;
      issued_q   <= 16'd0;
      retired_q  <= 16'd0;
      lat_q      <= 16'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_i) begin
            issued_q   <= 16'd0;
            retired_q  <= 16'd0;
            lat_q      <= 16'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 3'd0;
            wait_q     <= 4'd0;
            busy_q     <= 1'b1;
            if (IDLE_CYC != 0) begin
              state_q <= ST_WAIT;
            end else if (EXEC_N != 16'd0) begin
              state_q    <= ST_RUN;
              in_valid_q <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_WAIT: begin
          if (wait_q == IDLE_LAST) begin
            if (EXEC_N != 16'd0) begin
              state_q    <= ST_RUN;
              in_valid_q <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
            end
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (err_any_s) begin
            // Counters freeze on the failing cycle; only the highest-priority code is kept.
            state_q    <= ST_ERR;
            in_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b1;
            err_code_q <= err_sel_s;
          end else begin
            if (in_valid_q) begin
              issued_q <= issued_d;
            end
            if (out_valid_i) begin
              retired_q <= retired_d;
            end else if (retired_q == 16'd0) begin
              lat_q <= lat_d;
            end
            if (state_q == ST_RUN) begin
              if (issued_d >= EXEC_N) begin
                state_q    <= ST_DRAIN;
                in_valid_q <= 1'b0;
              end
            end else if (retired_q >= EXEC_N) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          in_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_valid_o    = in_valid_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign err_code_o    = err_code_q;
  assign issued_cnt_o  = issued_q;
  assign retired_cnt_o = retired_q;

`ifdef SP_SEQ_CYCLE_CNT_EN
  logic [31:0] run_cycles_q;
  logic [3:0]  first_lat_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_cycles_q <= 32'd0;
      first_lat_q  <= 4'd0;
    end else if (idle_like_s && start_i) begin
      run_cycles_q <= 32'd0;
      first_lat_q  <= 4'd0;
    end else if (busy_q) begin
      if (run_cycles_q != 32'hFFFF_FFFF) begin
        run_cycles_q <= run_cycles_q + 32'd1;
      end
      if (mon_s && (retired_q == 16'd0) && out_valid_i && !err_any_s) begin
        first_lat_q <= lat_q[3:0];
      end
    end
  end

  assign run_cycles_o = run_cycles_q;
  assign first_lat_o  = first_lat_q;
`endif

endmodule

// File: tb/tb_sp_inst_sequencer.sv
// Directed self-checking bench for sp_inst_sequencer with a simple SP core model driving inst_addr/out_valid.
module tb_sp_inst_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rom_we = 1'b0;
  logic [8:0]  rom_waddr = 9'd0;
  logic [31:0] rom_wdata = 32'd0;
  logic [31:0] inst_addr = 32'd0;
  logic        out_valid = 1'b0;
  logic        in_valid;
  logic [31:0] inst;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  err_code;
  logic [15:0] issued_cnt;
  logic [15:0] retired_cnt;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] WBASE = 32'hA5A5_0000;
  localparam logic [31:0] NEWW  = 32'hDEAD_BEEF;
  localparam logic [31:0] JUNK  = 32'h1234_5678;

  sp_inst_sequencer dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .rom_we_i     (rom_we),
    .rom_waddr_i  (rom_waddr),
    .rom_wdata_i  (rom_wdata),
    .inst_addr_i  (inst_addr),
    .out_valid_i  (out_valid),
    .in_valid_o   (in_valid),
    .inst_o       (inst),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .err_code_o   (err_code),
    .issued_cnt_o (issued_cnt),
    .retired_cnt_o(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Leaves the bench one step into the first RUN cycle (two WAIT cycles after start).
  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
  endtask

  // Core model: fetches word c at RUN cycle c, retires on cycles ov_first..ov_last.
  task automatic run_core(input int ncyc, input int ov_first, input int ov_last,
                          input int bad_c, input logic [31:0] bad_addr,
                          output int done_c, output int err_c, output int iv_cnt);
    done_c = -1;
    err_c  = -1;
    iv_cnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (done_c < 0 && done === 1'b1) done_c = c;
      if (err_c < 0 && err === 1'b1) err_c = c;
      inst_addr = (c == bad_c) ? bad_addr : 32'(c * 4);
      out_valid = (c >= ov_first) && (c <= ov_last);
      #1;
      if (in_valid === 1'b1) iv_cnt++;
      tick();
    end
    out_valid = 1'b0;
    inst_addr = 32'd0;
  endtask

  task automatic test_reset();
    tick();
    checks++; if (in_valid !== 1'b0) begin failures++; $display("FAIL rst_in_valid got=%b exp=0", in_valid); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b%b exp=000", busy, done, err); end
    checks++; if (err_code !== 3'd0 || issued_cnt !== 16'd0 || retired_cnt !== 16'd0) begin failures++; $display("FAIL rst_counts got=%0d/%0d/%0d exp=0/0/0", err_code, issued_cnt, retired_cnt); end
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      rom_we = 1'b1;
      rom_waddr = 9'(i);
      rom_wdata = WBASE + 32'(i);
      tick();
    end
    rom_we = 1'b0;
    start_run();
    inst_addr = 32'd0;
    #1;
    checks++; if (in_valid !== 1'b1 || inst !== WBASE) begin failures++; $display("FAIL run_first_inst got=%b/%h exp=1/%h", in_valid, inst, WBASE); end
    tick();
    inst_addr = 32'd4;
    #1;
    checks++; if (inst !== WBASE + 32'd1) begin failures++; $display("FAIL run_second_inst got=%h exp=%h", inst, WBASE + 32'd1); end
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (in_valid !== 1'b0 || busy !== 1'b0 || inst !== 32'd0) begin failures++; $display("FAIL async_rst_iv got=%b/%b/%h exp=0/0/0", in_valid, busy, inst); end
    checks++; if (done !== 1'b0 || err !== 1'b0 || issued_cnt !== 16'd0 || retired_cnt !== 16'd0) begin failures++; $display("FAIL async_rst_cnt got=%b/%b/%0d/%0d exp=0/0/0/0", done, err, issued_cnt, retired_cnt); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    start_run();
    inst_addr = 32'd0;
    #1;
    checks++; if (inst !== WBASE) begin failures++; $display("FAIL rom_after_rst got=%h exp=%h", inst, WBASE); end
    reset_pulse();
  endtask

  task automatic test_pass();
    int dc, ec, iv;
    start_run();
    run_core(335, 3, 327, -1, 32'd0, dc, ec, iv);
    checks++; if (dc !== 329) begin failures++; $display("FAIL pass_done_cycle got=%0d exp=329", dc); end
    checks++; if (ec !== -1) begin failures++; $display("FAIL pass_no_err got=%0d exp=-1", ec); end
    checks++; if (iv !== 325) begin failures++; $display("FAIL pass_in_valid_cycles got=%0d exp=325", iv); end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || err_code !== 3'd0) begin failures++; $display("FAIL pass_status got=%b/%b/%0d exp=1/0/0", done, busy, err_code); end
    checks++; if (retired_cnt !== 16'd325 || issued_cnt !== 16'd325) begin failures++; $display("FAIL pass_counts got=%0d/%0d exp=325/325", retired_cnt, issued_cnt); end
    checks++; if (inst !== 32'd0) begin failures++; $display("FAIL done_inst_zero got=%h exp=0", inst); end
  endtask

  task automatic test_latency();
    int dc, ec, iv;
    start_run();
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL restart_clears got=%b/%b exp=0/1", done, busy); end
    run_core(14, 100000, -1, -1, 32'd0, dc, ec, iv);
    checks++; if (ec !== 10) begin failures++; $display("FAIL lat_err_cycle got=%0d exp=10", ec); end
    checks++; if (err_code !== 3'd1 || in_valid !== 1'b0 || retired_cnt !== 16'd0) begin failures++; $display("FAIL lat_status got=%0d/%b/%0d exp=1/0/0", err_code, in_valid, retired_cnt); end
  endtask

  task automatic test_drop();
    int dc, ec, iv;
    start_run();
    run_core(110, 2, 101, -1, 32'd0, dc, ec, iv);
    checks++; if (ec !== 103) begin failures++; $display("FAIL drop_err_cycle got=%0d exp=103", ec); end
    checks++; if (err_code !== 3'd2 || retired_cnt !== 16'd100) begin failures++; $display("FAIL drop_status got=%0d/%0d exp=2/100", err_code, retired_cnt); end
    checks++; if (issued_cnt !== 16'd102) begin failures++; $display("FAIL drop_issued_frozen got=%0d exp=102", issued_cnt); end
  endtask

  task automatic test_extra();
    int dc, ec, iv;
    start_run();
    run_core(335, 3, 328, -1, 32'd0, dc, ec, iv);
    checks++; if (ec !== 329 || dc !== -1) begin failures++; $display("FAIL extra_err_cycle got=%0d/%0d exp=329/-1", ec, dc); end
    checks++; if (err_code !== 3'd3 || retired_cnt !== 16'd325) begin failures++; $display("FAIL extra_status got=%0d/%0d exp=3/325", err_code, retired_cnt); end
  endtask

  task automatic test_bad_addr();
    int dc, ec, iv;
    start_run();
    run_core(14, 100000, -1, 9, 32'h0000_0802, dc, ec, iv);
    checks++; if (ec !== 10 || err_code !== 3'd4) begin failures++; $display("FAIL addr_prio got=%0d/%0d exp=10/4", ec, err_code); end
    start_run();
    run_core(10, 2, 100, 4, 32'h0000_0800, dc, ec, iv);
    checks++; if (ec !== 5 || err_code !== 3'd4) begin failures++; $display("FAIL addr_range got=%0d/%0d exp=5/4", ec, err_code); end
  endtask

  task automatic test_lat_edge();
    int dc, ec, iv;
    start_run();
    run_core(13, 9, 20, -1, 32'd0, dc, ec, iv);
    checks++; if (ec !== -1 || err !== 1'b0 || retired_cnt !== 16'd4) begin failures++; $display("FAIL lat_edge_pass got=%0d/%b/%0d exp=-1/0/4", ec, err, retired_cnt); end
    reset_pulse();
  endtask

  task automatic test_load_start();
    rom_we = 1'b1;
    rom_waddr = 9'd0;
    rom_wdata = NEWW;
    start = 1'b1;
    tick();
    rom_we = 1'b0;
    start = 1'b0;
    tick();
    tick();
    inst_addr = 32'd0;
    rom_we = 1'b1;
    rom_waddr = 9'd1;
    rom_wdata = JUNK;
    #1;
    checks++; if (inst !== NEWW) begin failures++; $display("FAIL load_start_inst got=%h exp=%h", inst, NEWW); end
    tick();
    rom_we = 1'b0;
    inst_addr = 32'd4;
    #1;
    checks++; if (inst !== WBASE + 32'd1) begin failures++; $display("FAIL we_in_run_ignored got=%h exp=%h", inst, WBASE + 32'd1); end
    reset_pulse();
    inst_addr = 32'd4;
    #1;
    checks++; if (inst !== 32'd0 || in_valid !== 1'b0) begin failures++; $display("FAIL idle_inst_zero got=%h/%b exp=0/0", inst, in_valid); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_latency();
    test_drop();
    test_extra();
    test_bad_addr();
    test_lat_edge();
    test_load_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
